// File: rtl/fifo_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_pkg
// Brief    : Shared types and constants for the fifo_burst_drain block.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_burst_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      HDR   = 2'd2
   } state_t;

   localparam int c_burst_cnt_w = 16;

   // The header word carries the latched burst length starting at this bit.
   localparam int c_hdr_len_lsb = 0;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_out_reg
// Brief    : Single-entry registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_out_reg
   import fifo_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   input  logic                  i_ready,
   output logic                  o_can_load,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  last_q,  last_d;

   // The slot is free when empty or when its current word leaves this cycle.
   assign o_can_load = !valid_q | i_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (i_load) begin
         valid_d = 1'b1;
         data_d  = i_data;
         last_d  = i_last;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_drain
// Brief    : Pops a look-ahead FIFO in fixed-length bursts onto a stream,
//            flushing partial bursts on idle timeout or flush request.
// Options  : FIFO_BURST_HDR_EN - prefix each burst with a length header word
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_drain
   import fifo_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int BURST_LEN  = 16,
   parameter int TIMEOUT    = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fifo_empty,
   input  logic [ADDR_WIDTH:0]      fifo_uw,
   input  logic [DATA_WIDTH-1:0]    fifo_data,
   output logic                     fifo_rd_en,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_last,
   output logic                     busy,
   output logic [c_burst_cnt_w-1:0] burst_cnt
);

   localparam int                  c_tcnt_w    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit                  c_tout_en   = (TIMEOUT > 0);
   localparam logic [ADDR_WIDTH:0] c_burst_len = (ADDR_WIDTH + 1)'(BURST_LEN);
   localparam logic [ADDR_WIDTH:0] c_rem_one   = (ADDR_WIDTH + 1)'(1);
   localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [c_tcnt_w-1:0] c_tcnt_one  = c_tcnt_w'(1);
   localparam logic [c_burst_cnt_w-1:0] c_cnt_one = c_burst_cnt_w'(1);

`ifdef FIFO_BURST_HDR_EN
   localparam state_t c_start_state = HDR;
`else
   localparam state_t c_start_state = BURST;
`endif

   state_t                     state_q,      state_d;
   logic [ADDR_WIDTH:0]        remain_q,     remain_d;
   logic [c_tcnt_w-1:0]        tcnt_q,       tcnt_d;
   logic                       flush_pend_q, flush_pend_d;
   logic [c_burst_cnt_w-1:0]   burst_cnt_q,  burst_cnt_d;

   logic                  w_can_load;
   logic                  w_uw_nz;
   logic                  w_start_full;
   logic                  w_start_flush;
   logic                  w_start_tout;
   logic                  w_start;
   logic [ADDR_WIDTH:0]   w_len;
   logic                  w_pop;
   logic                  w_hdr_load;
   logic [DATA_WIDTH-1:0] w_hdr_word;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic                  w_load_last;

   // Start conditions, listed in priority order; all only matter in IDLE.
   assign w_uw_nz       = (fifo_uw != '0);
   assign w_start_full  = (fifo_uw >= c_burst_len);
   assign w_start_flush = flush_pend_q & w_uw_nz;
   assign w_start_tout  = c_tout_en & (tcnt_q == c_tcnt_last) & w_uw_nz;
   assign w_start       = (state_q == IDLE) & (w_start_full | w_start_flush | w_start_tout);
   assign w_len         = w_start_full ? c_burst_len : fifo_uw;

   assign w_pop = (state_q == BURST) & (remain_q != '0) & !fifo_empty & w_can_load;

   assign w_hdr_word = DATA_WIDTH'(remain_q) << c_hdr_len_lsb;
`ifdef FIFO_BURST_HDR_EN
   assign w_hdr_load = (state_q == HDR) & w_can_load;
`else
   assign w_hdr_load = 1'b0;
`endif

   assign w_load      = w_pop | w_hdr_load;
   assign w_load_data = w_hdr_load ? w_hdr_word : fifo_data;
   assign w_load_last = w_pop & (remain_q == c_rem_one);

   always_comb begin
      state_d      = state_q;
      remain_d     = remain_q;
      tcnt_d       = tcnt_q;
      flush_pend_d = flush_pend_q | flush;
      burst_cnt_d  = burst_cnt_q;

      case (state_q)
         IDLE: begin
            if (w_start) begin
               remain_d     = w_len;
               tcnt_d       = '0;
               flush_pend_d = 1'b0;
               state_d      = c_start_state;
            end else if (!w_uw_nz) begin
               // Nothing to drain: a flush request here has no effect.
               tcnt_d       = '0;
               flush_pend_d = 1'b0;
            end else if (c_tout_en && (fifo_uw < c_burst_len)) begin
               tcnt_d = tcnt_q + c_tcnt_one;
            end
         end
         BURST: begin
            if (w_pop) begin
               remain_d = remain_q - c_rem_one;
               if (remain_q == c_rem_one) begin
                  burst_cnt_d = burst_cnt_q + c_cnt_one;
                  state_d     = IDLE;
               end
            end
         end
`ifdef FIFO_BURST_HDR_EN
         HDR: begin
            if (w_can_load) begin
               state_d = BURST;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         remain_q     <= '0;
         tcnt_q       <= '0;
         flush_pend_q <= 1'b0;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         remain_q     <= remain_d;
         tcnt_q       <= tcnt_d;
         flush_pend_q <= flush_pend_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   fifo_burst_out_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_data     (w_load_data),
      .i_last     (w_load_last),
      .i_ready    (m_ready),
      .o_can_load (w_can_load),
      .o_valid    (m_valid),
      .o_data     (m_data),
      .o_last     (m_last)
   );

   assign fifo_rd_en = w_pop;
   assign busy       = (state_q != IDLE);
   assign burst_cnt  = burst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_drain
// Brief    : Self-checking bench: FIFO stand-in, stream scoreboard, directed
//            and randomized traffic. Honours FIFO_BURST_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_drain;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int BL = 16;
   localparam int TO = 64;
`ifdef FIFO_BURST_HDR_EN
   localparam int c_hdr_extra = 1;
`else
   localparam int c_hdr_extra = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [AW:0]   fifo_uw = '0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd_en;
   logic          flush = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic [15:0]   burst_cnt;

   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   int            rdy_mode = 0;
   int            rdy_ph = 0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fifo_burst_drain #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BURST_LEN  (BL),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_uw    (fifo_uw),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .burst_cnt  (burst_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   // Look-ahead FIFO stand-in; outputs update via NBA so the DUT sees clean edges.
   logic [DW-1:0] fq[$];
   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
      end else begin
         if (fifo_rd_en && fq.size() > 0) void'(fq.pop_front());
         if (wr_en) fq.push_back(wr_data);
      end
      fifo_uw    <= (AW + 1)'(fq.size());
      fifo_empty <= (fq.size() == 0);
      fifo_data  <= (fq.size() > 0) ? fq[0] : '0;
   end

   // Downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random ~70%, else never.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_ready = 1'b1;
         1: begin
            m_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
            rdy_ph++;
         end
         2: m_ready = ($urandom_range(0, 9) < 7);
         default: m_ready = 1'b0;
      endcase
   end

   // Reference model: words leave in write order; each burst's length is the
   // used count seen in the cycle it started, capped at BL.
   logic [DW-1:0] exp_q[$];
   int            len_q[$];
   int            words_in_burst = 0;
   int            bursts_seen = 0;
   int            acc_cnt = 0;
   int            prev_uw = 0;
   bit            prev_busy = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
`ifdef FIFO_BURST_HDR_EN
   bit            hdr_due = 1'b1;
`endif

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         len_q.delete();
         words_in_burst = 0;
         bursts_seen    = 0;
         prev_busy      = 1'b0;
         prev_stall     = 1'b0;
         prev_uw        = 0;
`ifdef FIFO_BURST_HDR_EN
         hdr_due        = 1'b1;
`endif
      end else begin
         if (prev_stall) begin
            check_eq("stall_valid", m_valid, 1);
            check_eq("stall_data", m_data, prev_data);
            check_eq("stall_last", m_last, prev_last);
         end
         if (m_valid && m_ready) begin
            acc_cnt++;
            if (len_q.size() == 0) begin
               check_eq("burst_known", len_q.size(), 1);
            end else begin
`ifdef FIFO_BURST_HDR_EN
               if (hdr_due) begin
                  check_eq("hdr_word", m_data, len_q[0]);
                  check_eq("hdr_last", m_last, 0);
                  hdr_due = 1'b0;
               end else
`endif
               begin
                  check_eq("word_avail", exp_q.size() != 0, 1);
                  if (exp_q.size() != 0) check_eq("data", m_data, exp_q.pop_front());
                  words_in_burst++;
                  check_eq("last", m_last, words_in_burst == len_q[0]);
                  if (words_in_burst == len_q[0]) begin
                     void'(len_q.pop_front());
                     words_in_burst = 0;
                     bursts_seen++;
`ifdef FIFO_BURST_HDR_EN
                     hdr_due = 1'b1;
`endif
                  end
               end
            end
         end
         if (busy && !prev_busy) len_q.push_back((prev_uw >= BL) ? BL : prev_uw);
         prev_busy  = busy;
         prev_uw    = int'(fifo_uw);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fifo_uw == 0 && !busy && !m_valid && exp_q.size() == 0) && n < budget);
      check_eq({tag, "_drained"}, (fifo_uw == 0 && !busy && !m_valid && exp_q.size() == 0), 1);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int first_pop;
      int base;
      bit seen;
      int n;

      // Reset values
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid", m_valid, 0);
      check_eq("rst_last", m_last, 0);
      check_eq("rst_data", m_data, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_cnt", burst_cnt, 0);
      check_eq("rst_rden", fifo_rd_en, 0);
      tick();
      rst = 1'b0;
      tick();

      // Full burst from 20 words
      rdy_mode = 0;
      for (int i = 0; i < 20; i++) write_word(DW'(i));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(burst_cnt == 1 && !m_valid) && n < 100);
      check_eq("full_cnt", burst_cnt, 1);
      check_eq("full_rem_uw", fifo_uw, 4);
      check_eq("full_busy", busy, 0);
      check_eq("full_seen", bursts_seen, 1);
      tick();
      wait_idle("tail", 300);
      check_eq("tail_cnt", burst_cnt, 2);

      // Idle timeout on a 5-word partial burst
      for (int i = 0; i < 5; i++) write_word(DW'(32'h100 + i));
      first_pop = -1;
      for (int i = 0; i < 200 && first_pop < 0; i++) begin
         @(negedge clk);
         k = i + 5;
         if (fifo_rd_en) first_pop = k;
      end
      check_eq("tout_first_pop", first_pop, TO + 1 + c_hdr_extra);
      tick();
      wait_idle("tout", 100);
      check_eq("tout_cnt", burst_cnt, 3);

      // Backpressure with ready pattern 1,0,0,1
      rdy_mode = 1;
      for (int i = 0; i < 16; i++) write_word(DW'(32'hA000 + i));
      wait_idle("bp", 300);
      check_eq("bp_cnt", burst_cnt, 4);
      rdy_mode = 0;
      tick();

      // Flush of a 3-word partial burst
      for (int i = 0; i < 3; i++) write_word(DW'(32'hF00 + i));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      check_eq("flush_start", seen, 1);
      tick();
      wait_idle("flush", 100);
      check_eq("flush_cnt", burst_cnt, 5);

      // Flush with nothing queued
      flush = 1'b1;
      tick();
      flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy || m_valid) seen = 1'b1;
      end
      check_eq("flush_empty_quiet", seen, 0);
      check_eq("flush_empty_cnt", burst_cnt, 5);
      tick();

      // Reset in the middle of a burst
      base = acc_cnt;
      for (int i = 0; i < 16; i++) write_word(DW'(32'hB000 + i));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((acc_cnt - base) < 7 && n < 100);
      check_eq("mid_reached", (acc_cnt - base) >= 7, 1);
      tick();
      rst = 1'b1;
      rdy_mode = 3;
      tick();
      @(negedge clk);
      check_eq("mid_valid", m_valid, 0);
      check_eq("mid_busy", busy, 0);
      check_eq("mid_cnt", burst_cnt, 0);
      check_eq("mid_rden", fifo_rd_en, 0);
      tick();
      rst = 1'b0;
      rdy_mode = 0;
      tick();

      // Randomized traffic
      rdy_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) < 4 && fq.size() < 240) begin
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
            exp_q.push_back(wr_data);
         end else begin
            wr_en = 1'b0;
         end
         flush = ($urandom_range(0, 49) == 0);
         tick();
      end
      wr_en = 1'b0;
      flush = 1'b0;
      rdy_mode = 0;
      wait_idle("rand", 3000);
      check_eq("rand_cnt", burst_cnt, 16'(bursts_seen));
      check_eq("rand_len_q", len_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Downstream consumer of the look-ahead sync FIFO.
- Watches the FIFO's used-word count and pops words in fixed-length bursts.
- Emits them on a registered valid/ready stream with a last marker on the final word of each burst.
- Partial bursts are flushed after a configurable idle timeout or on an explicit flush request, so trailing data never stalls in the FIFO.

Parameters:
- DATA_WIDTH, 32, word width; must match the FIFO.
- ADDR_WIDTH, 8, FIFO address width; fifo_uw is ADDR_WIDTH+1 bits.
- BURST_LEN, 16, words per full burst; 1..2^ADDR_WIDTH.
- TIMEOUT, 64, idle cycles before a partial burst is forced; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- fifo_empty  in  1  FIFO empty flag
- fifo_uw  in  ADDR_WIDTH+1  FIFO used-word count
- fifo_data  in  DATA_WIDTH  FIFO look-ahead head word; valid while !fifo_empty
- fifo_rd_en  out  1  FIFO pop
- flush  in  1  single-cycle request to drain a partial burst now
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  output word
- m_last  out  1  final word of burst
- busy  out  1  burst in progress (state != IDLE)
- burst_cnt  out  16  completed bursts, wraps at 2^16

Interface decision: one clock, clk; rst is synchronous and active-high.

Behaviour:
- Reset values:
  - state=IDLE; fifo_rd_en=0; m_valid=0; m_data=0; m_last=0.
  - busy=0; burst_cnt=0; timeout counter=0; flush_pend=0.
- Output register semantics:
  - Single-entry output register; loads when !m_valid | m_ready.
  - m_valid drops on m_valid&m_ready with no new load.
  - m_data/m_last hold while m_valid & !m_ready.
- Pop rule:
  - fifo_rd_en = (state==BURST) & (remain!=0) & !fifo_empty & (!m_valid | m_ready).
  - The popped fifo_data is captured into the output register in the same edge, so latency is pop to m_valid = 1 cycle.
  - Full throughput is 1 word/cycle.
- State machine: IDLE, BURST (plus HDR with the optional feature).
- IDLE, start conditions (priority order):
  - fifo_uw >= BURST_LEN: len = BURST_LEN.
  - flush_pend & fifo_uw != 0: len = fifo_uw.
  - TIMEOUT != 0 & tcnt == TIMEOUT-1 & fifo_uw != 0: len = fifo_uw.
- IDLE, on start: remain <= len, tcnt <= 0, flush_pend <= 0, go to BURST.
- Timeout counter:
  - tcnt increments in IDLE while 0 < fifo_uw < BURST_LEN.
  - Clears when fifo_uw == 0 or on burst start.
- Flush:
  - flush is latched into flush_pend.
  - flush with fifo_uw == 0 in IDLE clears flush_pend with no burst.
  - flush during BURST stays pending and is evaluated on return to IDLE.
- BURST:
  - Each pop decrements remain.
  - The pop with remain == 1 loads m_last=1, increments burst_cnt and returns to IDLE.
  - A new burst may start the next cycle (back-to-back).
- Boundaries:
  - fifo_uw exactly BURST_LEN starts a full burst.
  - fifo_uw > 2^ADDR_WIDTH is impossible; no saturation is required.
  - The burst length is latched, so later writes do not extend the burst.
  - fifo_empty during BURST (cannot occur with a single consumer) stalls popping and is not an error.
  - Reset mid-burst clears everything; popped-but-undelivered words are discarded; the FIFO is expected to be cleared with it.
- Widths and counters:
  - remain is ADDR_WIDTH+1 bits.
  - tcnt is $clog2(TIMEOUT+1) bits, minimum 1.

Optional Feature:
- Macro: FIFO_BURST_HDR_EN.
- Defined:
  - Each burst start enters HDR instead of BURST.
  - HDR loads one header word into the output register: zero-extended len in bits [ADDR_WIDTH:0], all other bits 0, m_last=0. It is loaded when !m_valid | m_ready, with no FIFO pop.
  - HDR then moves to BURST; busy stays high in HDR.
- Undefined: no HDR state; stream contains data words only.

Decomposition:
- Package fifo_burst_pkg holds:
  - state enum typedef (IDLE, BURST, HDR);
  - burst_cnt width constant (16);
  - header field positions.
- One natural sub-module: fifo_burst_out_reg (the output register stage with its load rule), instantiated once.
- The rest stays flat.

Test Plan:
- Full burst: write 20 words (0..19), m_ready=1.
  - Expect 16 words 0..15, m_last only on 15.
  - burst_cnt=1; fifo_uw=4 remains; busy=0 afterwards.
- Timeout, TIMEOUT=64: write 5 words.
  - Expect no pop for 63 cycles, then a 5-word burst with m_last on word 4.
- Backpressure: 16 words with m_ready toggling 1,0,0,1 repeatedly.
  - Expect no loss or duplication; m_data stable while stalled; 16 words delivered in order.
- Flush: write 3 words, pulse flush.
  - Expect a 3-word burst starting within 2 cycles.
  - flush with an empty FIFO produces no output.
- Reset mid-burst: assert rst after 7 words of a 16-word burst.
  - Expect m_valid=0, busy=0, burst_cnt=0 next cycle; fifo_rd_en low.
- FIFO_BURST_HDR_EN: 16 words.
  - Expect header 0x00000010 first, then 16 data words, m_last on the final one.
